// File: rtl/issue_wait_queue.sv
// -----------------------------------------------------------------------------
// issue_wait_queue
//   In-order wait buffer that sits in front of the issue capability check.
//   Renamed ops are held in a circular FIFO. Every cycle the wakeup
//   (completion tag) bus is compared against the four operand tags of each
//   stored op, and matching operands get their ready flag set. The head op is
//   offered downstream with a valid/ready handshake. Downstream pops it once
//   all four ready flags (bits [7:4]) are set.
//
//   Op layout: [3:0] opaque, [4+k] operand k ready,
//              [8+k*TAG_W +: TAG_W] operand k tag, bits above carried as-is.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     rename presents an op
//   in_instr     op from rename
//   in_ready     space available (count < DEPTH)
//   out_valid    head entry valid (count != 0)
//   out_instr    head op, straight from storage
//   out_ready    downstream takes the head this cycle
//   wake_valid   per-port wakeup valid
//   wake_tag     per-port wakeup tag, port p at [p*TAG_W +: TAG_W]
//   flush        synchronous discard of all entries
//   count        occupied entries
// -----------------------------------------------------------------------------

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 40
`endif

// -----------------------------------------------------------------------------
// issue_wait_queue_wake
//   Per-op wakeup match. Takes the op's current ready flags and four operand
//   tags and returns the flags ORed with any same-cycle wakeup hit. Used once
//   per storage slot and once for the incoming op.
//
// Ports
//   i_rdy        current ready flags [3:0]
//   i_tags       operand tags, operand k at [k*TAG_W +: TAG_W]
//   i_wake_valid per-port wakeup valid
//   i_wake_tag   per-port wakeup tag
//   o_rdy        updated ready flags
// -----------------------------------------------------------------------------
module issue_wait_queue_wake #(
    parameter int TAG_W      = 6,
    parameter int WAKE_PORTS = 2
) (
    input  logic [3:0]                  i_rdy,
    input  logic [4*TAG_W-1:0]          i_tags,
    input  logic [WAKE_PORTS-1:0]       i_wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0] i_wake_tag,
    output logic [3:0]                  o_rdy
);

    logic [3:0] w_hit;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_opnd
            // Any port hitting this operand sets it; multiple hits simply OR.
            always_comb begin
                w_hit[k] = 1'b0;
                for (int p = 0; p < WAKE_PORTS; p++) begin
                    if (i_wake_valid[p] &&
                        (i_wake_tag[p*TAG_W +: TAG_W] == i_tags[k*TAG_W +: TAG_W]))
                        w_hit[k] = 1'b1;
                end
            end
        end
    endgenerate

    // Flags are sticky: this block only ever sets them.
    assign o_rdy = i_rdy | w_hit;

endmodule

// -----------------------------------------------------------------------------
module issue_wait_queue #(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,   // must be >= 8 + 4*TAG_W
    parameter int DEPTH      = 4,                // >= 2, any value
    parameter int TAG_W      = 6,
    parameter int WAKE_PORTS = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [INST_WIDTH-1:0]       in_instr,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [INST_WIDTH-1:0]       out_instr,
    input  logic                        out_ready,
    input  logic [WAKE_PORTS-1:0]       wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
    input  logic                        flush,
    output logic [CW-1:0]               count
);

    localparam int PW = $clog2(DEPTH);

    // ---------------------------------------------------------------- state
    logic [INST_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    // ---------------------------------------------------------------- wires
    logic                  w_enq;
    logic                  w_deq;
    logic [3:0]            w_in_rdy;
    logic [3:0]            w_ent_rdy [DEPTH];
    logic [INST_WIDTH-1:0] w_mem_nxt [DEPTH];

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status outputs come only from registered state: in_ready does not look
    // at out_ready, so a full queue never grants a pass-through slot.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign out_instr = r_mem[r_head];

    assign w_enq = in_valid  & in_ready;
    assign w_deq = out_valid & out_ready;

    // Enqueue-time capture: the incoming op sees the same wakeup bus as the
    // stored entries, so a completion coinciding with enqueue is not lost.
    issue_wait_queue_wake #(
        .TAG_W      (TAG_W),
        .WAKE_PORTS (WAKE_PORTS)
    ) u_wake_in (
        .i_rdy        (in_instr[7:4]),
        .i_tags       (in_instr[8 +: 4*TAG_W]),
        .i_wake_valid (wake_valid),
        .i_wake_tag   (wake_tag),
        .o_rdy        (w_in_rdy)
    );

    genvar e;
    generate
        for (e = 0; e < DEPTH; e++) begin : g_ent
            // Every slot is snooped regardless of occupancy; stale slots are
            // overwritten in full on their next enqueue, so this is harmless.
            issue_wait_queue_wake #(
                .TAG_W      (TAG_W),
                .WAKE_PORTS (WAKE_PORTS)
            ) u_wake (
                .i_rdy        (r_mem[e][7:4]),
                .i_tags       (r_mem[e][8 +: 4*TAG_W]),
                .i_wake_valid (wake_valid),
                .i_wake_tag   (wake_tag),
                .o_rdy        (w_ent_rdy[e])
            );

            // The enqueue write takes priority over the snoop update, so a
            // slot popped and refilled in the same cycle holds only the new op.
            always_comb begin
                w_mem_nxt[e]      = r_mem[e];
                w_mem_nxt[e][7:4] = w_ent_rdy[e];
                if (w_enq && (r_tail == PW'(e)))
                    w_mem_nxt[e] = {in_instr[INST_WIDTH-1:8], w_in_rdy, in_instr[3:0]};
            end
        end
    endgenerate

    // ---------------------------------------------------------------- update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (flush) begin
            // Flush wins over any same-cycle enqueue/dequeue; data is left.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= w_mem_nxt[i];
            if (w_enq)
                r_tail <= f_inc(r_tail);
            if (w_deq)
                r_head <= f_inc(r_head);
            if (w_enq && !w_deq)
                r_count <= r_count + CW'(1);
            else if (w_deq && !w_enq)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: tb/tb_issue_wait_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_wait_queue
//   Directed stimulus with a scoreboard: each tracked enqueue pushes the op as
//   it is expected to look when popped; a negedge monitor pops and compares
//   whenever the DUT completes a handshake. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_issue_wait_queue;

    localparam int W  = 40;
    localparam int D  = 4;
    localparam int TW = 6;
    localparam int WP = 2;
    localparam int CW = $clog2(D + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [W-1:0]      in_instr;
    logic              in_ready;
    logic              out_valid;
    logic [W-1:0]      out_instr;
    logic              out_ready;
    logic [WP-1:0]     wake_valid;
    logic [WP*TW-1:0]  wake_tag;
    logic              flush;
    logic [CW-1:0]     count;
    logic              rdy_en;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb [$];

    always #5 clk = ~clk;

    // Downstream gates on the ready flags, as the real capability check does.
    assign out_ready = rdy_en & (&out_instr[7:4]);

    issue_wait_queue #(
        .INST_WIDTH (W),
        .DEPTH      (D),
        .TAG_W      (TW),
        .WAKE_PORTS (WP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_ready  (out_ready),
        .wake_valid (wake_valid),
        .wake_tag   (wake_tag),
        .flush      (flush),
        .count      (count)
    );

    function automatic logic [W-1:0] mkop(input logic [3:0] lo, input logic [3:0] rdy,
                                          input logic [5:0] t0, input logic [5:0] t1,
                                          input logic [5:0] t2, input logic [5:0] t3,
                                          input logic [7:0] hi);
        return {hi, t3, t2, t1, t0, rdy, lo};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wake(input int p, input logic [5:0] tag);
        wake_valid    = '0;
        wake_tag      = '0;
        wake_valid[p] = 1'b1;
        wake_tag[p*TW +: TW] = tag;
    endtask

    task automatic clr_wake();
        wake_valid = '0;
        wake_tag   = '0;
    endtask

    // One-cycle enqueue attempt; tracked ops go to the scoreboard if accepted.
    task automatic enq1(input logic [W-1:0] op, input logic [W-1:0] exp, input bit track);
        in_valid = 1'b1;
        in_instr = op;
        if (track && in_ready)
            sb.push_back(exp);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: a handshake seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no pop", out_instr);
            end else begin
                logic [W-1:0] exp;
                exp = sb.pop_front();
                if (out_instr !== exp) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", out_instr, exp);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] op;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        flush    = 1'b0;
        rdy_en   = 1'b0;
        clr_wake();

        // ---- reset state
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        rst_n = 1'b1;
        step();

        // ---- single ready op: valid one cycle after enqueue, popped next edge
        rdy_en = 1'b1;
        op = mkop(4'h1, 4'hF, 6'd1, 6'd2, 6'd3, 6'd4, 8'hA1);
        enq1(op, op, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_count1",    64'(count),     64'd1);
        step();
        chk("t1_count0",    64'(count),     64'd0);

        // ---- staged wakeups: tags 5,9,9,12
        op = mkop(4'h2, 4'h0, 6'd5, 6'd9, 6'd9, 6'd12, 8'hB2);
        enq1(op, op | W'(8'hF0), 1'b1);
        chk("t2_rdy_init", 64'(out_instr[7:4]), 64'h0);
        set_wake(0, 6'd9);
        step();
        clr_wake();
        chk("t2_rdy_a",    64'(out_instr[7:4]), 64'h6);
        chk("t2_held_a",   64'(count),          64'd1);
        set_wake(1, 6'd5);
        step();
        clr_wake();
        chk("t2_rdy_b",    64'(out_instr[7:4]), 64'h7);
        chk("t2_held_b",   64'(count),          64'd1);
        set_wake(0, 6'd12);
        step();
        clr_wake();
        chk("t2_rdy_c",    64'(out_instr[7:4]), 64'hF);
        step();
        chk("t2_popped",   64'(count),          64'd0);

        // ---- wakeup coinciding with enqueue (operand 2 tag 7)
        op = mkop(4'h3, 4'b1011, 6'd1, 6'd2, 6'd7, 6'd3, 8'hC3);
        set_wake(0, 6'd7);
        enq1(op, op | W'(8'hF0), 1'b1);
        clr_wake();
        chk("t3_capture",  64'(out_instr[6]), 64'd1);
        step();
        chk("t3_popped",   64'(count),        64'd0);

        // ---- fill, then stream across the pointer wrap
        rdy_en = 1'b0;
        for (int n = 0; n < 4; n++) begin
            op = mkop(4'(n), 4'hF, 6'(n), 6'(n + 1), 6'(n + 2), 6'(n + 3), 8'(8'h40 + n));
            enq1(op, op, 1'b1);
        end
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        chk("t4_full_count", 64'(count),    64'd4);
        rdy_en = 1'b1;
        // First cycle: full, so only the pop happens; then pop+enqueue per cycle.
        for (int n = 4; n < 15; n++) begin
            op = mkop(4'(n), 4'hF, 6'(n), 6'(n + 1), 6'(n + 2), 6'(n + 3), 8'(8'h40 + n));
            in_valid = 1'b1;
            in_instr = op;
            if (in_ready)
                sb.push_back(op);
            step();
            chk("t4_stream_count", 64'(count), 64'd3);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && count != 0; c++)
            step();
        chk("t4_drained", 64'(count), 64'd0);

        // ---- flush with 3 entries and a same-cycle enqueue
        rdy_en = 1'b0;
        for (int n = 0; n < 3; n++)
            enq1(mkop(4'hD, 4'hF, 6'd1, 6'd1, 6'd1, 6'd1, 8'(8'hD0 + n)), '0, 1'b0);
        chk("t5_pre_count", 64'(count), 64'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = mkop(4'hE, 4'hF, 6'd2, 6'd2, 6'd2, 6'd2, 8'hDF);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_count",     64'(count),     64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready",  64'(in_ready),  64'd1);
        rdy_en = 1'b1;
        step();
        chk("t5_dropped",   64'(count),     64'd0);
        op = mkop(4'h5, 4'hF, 6'd3, 6'd3, 6'd3, 6'd3, 8'hE5);
        enq1(op, op, 1'b1);
        step();
        chk("t5_after",     64'(count),     64'd0);

        // ---- asynchronous reset mid-cycle with 2 entries
        rdy_en = 1'b0;
        enq1(mkop(4'h6, 4'hF, 6'd4, 6'd4, 6'd4, 6'd4, 8'hF6), '0, 1'b0);
        enq1(mkop(4'h7, 4'hF, 6'd4, 6'd4, 6'd4, 6'd4, 8'hF7), '0, 1'b0);
        chk("t6_pre_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready",  64'(in_ready),  64'd1);
        chk("t6_count",     64'(count),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rdy_en = 1'b1;
        op = mkop(4'h8, 4'hF, 6'd5, 6'd5, 6'd5, 6'd5, 8'h88);
        enq1(op, op, 1'b1);
        step();
        chk("t6_after",     64'(count), 64'd0);

        // ---- every tracked op must have been popped
        for (int c = 0; c < 20 && sb.size() != 0; c++)
            step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
